// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrating mux: packet FSM encoding and channel-index width.
package mux_pkg;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_if.sv
// N-channel beat input plus registered beat output of the arbitrating mux.
interface arb_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = mux_pkg::ch_w(NUM_CH)
);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );

endinterface

// File: rtl/arb_mux_arbiter.sv
// Rotating-priority arbiter: first requester at or above ptr, wrapping; purely combinational.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [CH_W-1:0] cand;
  logic            found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(ptr) + k) % NUM_CH);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Packet-aware N:1 arbitrating mux; one-cycle registered output, one beat per cycle sustained.
// A held output beat (out_valid && !out_ready) drops every in_ready until it drains.
module arb_mux
  import mux_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int ARB_MODE = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  arb_mux_if.slave bus
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int OFS_W = $clog2(NUM_CH * DATA_W);

  logic [0:0]        state;
  logic [CH_W-1:0]   lock_ch;
  logic [CH_W-1:0]   ptr;
  logic              run;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]   out_ch_q;

  logic [NUM_CH-1:0] arb_gnt;
  logic [CH_W-1:0]   arb_idx;
  logic [NUM_CH-1:0] ready;
  logic [CH_W-1:0]   sel_ch;
  logic [OFS_W-1:0]  sel_ofs;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              load_en;
  logic              xfer;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign load_en  = !out_valid_q || bus.out_ready;
  assign sel_ch   = (state == LOCKED) ? lock_ch : arb_idx;
  assign sel_ofs  = OFS_W'(sel_ch) * OFS_W'(DATA_W);
  assign sel_data = bus.in_data[sel_ofs +: DATA_W];
  assign sel_last = bus.in_last[sel_ch];

  // run keeps in_ready low for the first edge after reset release
  always_comb begin
    ready = '0;
    if (run && load_en) begin
      if (state == LOCKED) ready[lock_ch] = 1'b1;
      else                 ready = arb_gnt;
    end
  end

  assign xfer = |(ready & bus.in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      state       <= IDLE;
      lock_ch     <= '0;
      ptr         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      run <= 1'b1;
      if (load_en) begin
        out_valid_q <= xfer;
        if (xfer) begin
          out_data_q <= sel_data;
          out_last_q <= sel_last;
          out_ch_q   <= sel_ch;
        end
      end
      if (xfer) begin
        if (state == IDLE && !sel_last) begin
          state   <= LOCKED;
          lock_ch <= sel_ch;
        end else if (state == LOCKED && sel_last) begin
          state <= IDLE;
        end
        // pointer moves only when a packet completes; fixed mode keeps it at 0
        if (ARB_MODE == 1 && sel_last)
          ptr <= (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + 1'b1;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: packet sources feed a round-robin instance checked against a
// queue-based reference model; a second fixed-priority instance is checked for starvation.
module tb_arb_mux;

  localparam int NCH = 4;
  localparam int DW  = 8;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_mux_if #(.NUM_CH(NCH), .DATA_W(DW)) bus0 ();
  arb_mux_if #(.NUM_CH(NCH), .DATA_W(DW)) bus1 ();

  arb_mux #(.NUM_CH(NCH), .DATA_W(DW), .ARB_MODE(1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  arb_mux #(.NUM_CH(NCH), .DATA_W(DW), .ARB_MODE(0)) dut_fix (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;

  beat_t         exp_q[$];
  int            ch_log[$];
  int            tx_cnt = 0;
  int            rx_cnt = 0;
  logic [DW:0]   src_q [NCH][$];
  bit            rand_gap = 0;
  bit            rand_rdy = 0;

  // reference model state
  bit             m_ov = 0, m_locked = 0, m_run = 0, m_load = 1, m_xfer = 0, m_found = 0;
  int             m_lock = 0, m_ptr = 0, m_ch = 0, m_c = 0;
  logic [DW-1:0]  m_data = '0;
  logic           m_last = 1'b0;
  logic [NCH-1:0] exp_rdy = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model, evaluation half: expected in_ready from valids, lock and rotating pointer.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      m_load  = !m_ov || bus0.out_ready;
      exp_rdy = '0;
      if (m_run && m_load) begin
        if (m_locked) exp_rdy[m_lock] = 1'b1;
        else begin
          m_found = 0;
          for (int k = 0; k < NCH; k++) begin
            m_c = (m_ptr + k) % NCH;
            if (!m_found && bus0.in_valid[m_c]) begin
              exp_rdy[m_c] = 1'b1;
              m_found      = 1;
            end
          end
        end
      end
      chk("in_ready", bus0.in_ready, exp_rdy);
      chk("out_valid", bus0.out_valid, m_ov);
      m_xfer = 0;
      for (int c = 0; c < NCH; c++)
        if (exp_rdy[c] && bus0.in_valid[c]) begin
          m_xfer = 1;
          m_ch   = c;
          m_data = bus0.in_data[c*DW +: DW];
          m_last = bus0.in_last[c];
        end
    end
  end

  // Model, update half: commit the transfer decided at the preceding falling edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ov = 0; m_locked = 0; m_lock = 0; m_ptr = 0; m_run = 0; m_xfer = 0; m_load = 1;
      exp_q.delete();
    end else begin
      if (m_load) m_ov = m_xfer;
      if (m_xfer) begin
        exp_q.push_back('{ch: m_ch, data: m_data, last: m_last});
        if (m_last) begin
          m_locked = 0;
          m_ptr    = (m_ch + 1) % NCH;
        end else if (!m_locked) begin
          m_locked = 1;
          m_lock   = m_ch;
        end
      end
      m_run  = 1;
      m_xfer = 0;
    end
  end

  // Monitor: every presented beat must match the scoreboard head; pop on handshake.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus0.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: ch %0d data %0h with no beat expected", bus0.out_ch, bus0.out_data);
      end else begin
        chk("out_ch", bus0.out_ch, exp_q[0].ch);
        chk("out_data", bus0.out_data, exp_q[0].data);
        chk("out_last", bus0.out_last, exp_q[0].last);
        if (bus0.out_ready) begin
          ch_log.push_back(exp_q[0].ch);
          rx_cnt++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      if (src_q[c].size() != 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
        bus0.in_valid[c]          = 1'b1;
        bus0.in_data[c*DW +: DW]  = src_q[c][0][DW-1:0];
        bus0.in_last[c]           = src_q[c][0][DW];
      end else begin
        bus0.in_valid[c]          = 1'b0;
        bus0.in_data[c*DW +: DW]  = DW'($urandom);
        bus0.in_last[c]           = 1'($urandom);
      end
    end
  endtask

  task automatic add_pkt(input int c, input int len, input int base);
    logic [DW-1:0] d;
    logic          l;
    for (int k = 0; k < len; k++) begin
      d = DW'(base + k);
      l = (k == len - 1);
      src_q[c].push_back({l, d});
    end
    tx_cnt += len;
  endtask

  task automatic cycle_rest();
    logic [NCH-1:0] acc;
    acc = bus0.in_valid & bus0.in_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++)
      if (acc[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
    if (rand_rdy) bus0.out_ready = ($urandom_range(0, 3) != 0);
    drive();
  endtask

  task automatic cycle();
    @(negedge clk);
    cycle_rest();
  endtask

  function automatic bit srcs_empty();
    for (int c = 0; c < NCH; c++)
      if (src_q[c].size() != 0) return 0;
    return 1;
  endfunction

  task automatic run_until_log(input int n, input int budget, input string name);
    int i = 0;
    while (ch_log.size() < n && i < budget) begin
      cycle();
      i++;
    end
    if (ch_log.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d beats seen, %0d required", name, ch_log.size(), n);
    end
  endtask

  task automatic wait_src(input int c, input int size, input int budget, input string name);
    int i = 0;
    while (src_q[c].size() > size && i < budget) begin
      cycle();
      i++;
    end
    if (src_q[c].size() > size) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d beats left on ch%0d, %0d required", name, src_q[c].size(), c, size);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int i = 0;
    while (!(srcs_empty() && exp_q.size() == 0) && i < budget) begin
      cycle();
      i++;
    end
    if (!(srcs_empty() && exp_q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s: drain timeout, %0d beats in flight", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < NCH; c++) src_q[c].delete();
    bus0.in_valid  = '1;
    bus0.in_last   = '1;
    bus0.out_ready = 1'b1;
    rand_gap = 0;
    rand_rdy = 0;
    #2;
    chk("rst in_ready", bus0.in_ready, 0);
    chk("rst out_valid", bus0.out_valid, 0);
    chk("rst out_data", bus0.out_data, 0);
    chk("rst out_last", bus0.out_last, 0);
    chk("rst out_ch", bus0.out_ch, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ch_log.delete();
    tx_cnt = 0;
    rx_cnt = 0;
    drive();
  endtask

  int            rr_exp[5]   = '{0, 1, 2, 3, 0};
  int            lock_exp[5] = '{1, 1, 1, 3, 0};
  logic [DW-1:0] held;

  initial begin
    bus0.in_data   = '0;
    bus1.in_valid  = '0;
    bus1.in_data   = '0;
    bus1.in_last   = '0;
    bus1.out_ready = 1'b1;

    // round robin over four always-valid single-beat channels
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) add_pkt(c, 1, 16 * (c + 1) + k);
    drive();
    run_until_log(5, 40, "rr");
    for (int i = 0; i < 5; i++) chk($sformatf("rr grant %0d", i), ch_log[i], rr_exp[i]);
    drain(100, "rr");

    // a 3-beat packet on ch1 holds the lock while ch0 and ch3 wait
    do_reset();
    add_pkt(1, 3, 8'h40);
    drive();
    wait_src(1, 2, 20, "lock start");
    add_pkt(0, 1, 8'h50);
    add_pkt(3, 1, 8'h60);
    drive();
    run_until_log(5, 40, "lock");
    for (int i = 0; i < 5; i++) chk($sformatf("lock grant %0d", i), ch_log[i], lock_exp[i]);
    drain(100, "lock");

    // output stall for four cycles, then release
    do_reset();
    add_pkt(2, 3, 8'h80);
    add_pkt(1, 2, 8'h90);
    add_pkt(3, 1, 8'hA0);
    drive();
    for (int i = 0; i < 20 && !bus0.out_valid; i++) cycle();
    bus0.out_ready = 1'b0;
    held = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) held = (exp_q.size() != 0) ? exp_q[0].data : '0;
      chk("bp out_valid", bus0.out_valid, 1);
      chk("bp out_data stable", bus0.out_data, held);
      chk("bp in_ready", bus0.in_ready, 0);
      cycle_rest();
    end
    bus0.out_ready = 1'b1;
    drain(100, "bp");
    chk("bp beat count", rx_cnt, tx_cnt);

    // idle gap right after the last accepted beat
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle out_valid", bus0.out_valid, 0);
      chk("idle in_ready", bus0.in_ready, 0);
      cycle_rest();
    end

    // reset in the middle of a locked ch2 packet, pointer already moved to 2
    do_reset();
    add_pkt(1, 1, 8'hB0);
    add_pkt(2, 3, 8'hC0);
    drive();
    wait_src(2, 1, 30, "rst_mid open");
    do_reset();
    add_pkt(0, 1, 8'hD0);
    add_pkt(2, 1, 8'hE0);
    drive();
    run_until_log(2, 20, "rst_mid");
    chk("rst_mid first grant", ch_log[0], 0);
    chk("rst_mid second grant", ch_log[1], 2);
    drain(50, "rst_mid");

    // randomized packets, gaps and output backpressure
    do_reset();
    rand_gap = 1;
    rand_rdy = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++)
        if (src_q[c].size() == 0 && $urandom_range(0, 5) == 0)
          add_pkt(c, $urandom_range(1, 4), $urandom_range(0, 255));
      cycle();
    end
    rand_gap = 0;
    rand_rdy = 0;
    bus0.out_ready = 1'b1;
    drive();
    drain(300, "rand");
    chk("rand beat count", rx_cnt, tx_cnt);

    // fixed priority: ch1 always beats ch3
    do_reset();
    bus1.in_valid = 4'b1010;
    bus1.in_last  = '1;
    bus1.in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("fix in_ready", bus1.in_ready, 4'b0010);
      if (k > 0) begin
        chk("fix out_ch", bus1.out_ch, 1);
        chk("fix out_data", bus1.out_data, 8'h11);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 4, as the number of input channels (legal range 2..16).
REQ-002 The block SHALL take parameter DATA_W, default 8, as the data width per channel (legal range 1..64).
REQ-003 The block SHALL take parameter ARB_MODE, default 1, as the arbitration mode: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock), then rst_n input 1 (asynchronous, active-low reset).
REQ-005 in_valid  input  NUM_CH  per-channel beat valid.
REQ-006 in_data  input  NUM_CH*DATA_W  channel i data in bits [i*DATA_W +: DATA_W].
REQ-007 in_last  input  NUM_CH  per-channel last beat of packet.
REQ-008 in_ready  output  NUM_CH  per-channel beat accepted this cycle when high with in_valid.
REQ-009 out_valid  output  1  registered output beat valid.
REQ-010 out_data  output  DATA_W  registered output data.
REQ-011 out_last  output  1  registered last flag.
REQ-012 out_ch  output  CH_W  source channel of the current output beat; CH_W = max(1, clog2(NUM_CH)).
REQ-013 out_ready  input  1  downstream accepts the output beat.

Function
REQ-014 load_en SHALL equal (!out_valid || out_ready); the output register SHALL load only when load_en is high and a beat is transferred.
REQ-015 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i]; at most one in_ready bit SHALL be high per cycle.
REQ-016 Latency SHALL be one cycle: a beat transferred in cycle n appears on out_* in cycle n+1; sustained throughput SHALL be one beat per cycle when out_ready is held high.
REQ-017 While out_valid && !out_ready, out_data, out_last and out_ch SHALL hold stable and all in_ready bits SHALL be low.
REQ-018 The FSM SHALL have two states: IDLE (no packet open) and LOCKED (packet open on lock_ch).
REQ-019 In IDLE with load_en high, the arbiter SHALL grant one valid channel; priority order starts at ptr and proceeds upward, wrapping from NUM_CH-1 to 0.
REQ-020 In IDLE, if no in_valid bit is set, in_ready SHALL be all zero and the FSM SHALL stay in IDLE.
REQ-021 IDLE -> LOCKED SHALL occur on a granted transfer with in_last low; lock_ch SHALL capture the granted index.
REQ-022 In LOCKED, in_ready[lock_ch] SHALL equal load_en and all other in_ready bits SHALL be low, whatever the other channels' valids.
REQ-023 LOCKED -> IDLE SHALL occur on the transfer of a beat on lock_ch with in_last high.
REQ-024 A single-beat packet (in_last high on the granted beat) SHALL leave the FSM in IDLE.
REQ-025 In ARB_MODE 1, ptr SHALL update to (granted channel + 1) mod NUM_CH on each packet-completing transfer, and SHALL hold otherwise.
REQ-026 In ARB_MODE 0, ptr SHALL remain 0 permanently.
REQ-027 out_valid SHALL clear on a cycle with out_ready high and no transfer.

Reset
REQ-028 When rst_n is low, the following SHALL be forced asynchronously: out_valid 0, out_data 0, out_last 0, out_ch 0, state IDLE, lock_ch 0, ptr 0, in_ready all 0.
REQ-029 A reset asserted mid-packet SHALL discard the lock and any held output beat; after release, arbitration SHALL restart from ptr 0.
REQ-030 No transfer SHALL occur in the first clock edge after rst_n deasserts; in_ready SHALL be combinational from the registered state, so transfers are possible from the cycle after release.

Structure
REQ-031 A shared package mux_pkg SHALL hold the FSM state encoding (IDLE, LOCKED) and the CH_W width function.
REQ-032 Arbitration SHALL be a sub-module rr_arbiter (inputs: req vector and ptr; outputs: one-hot grant and grant index), instantiated once.
REQ-033 The datapath select SHALL be a parametrised indexed part-select; no per-channel gate instances.

Verification
REQ-034 Reset mid-packet: open a packet on ch2, pulse rst_n low -> all outputs 0; next packet, with ch0 and ch2 both valid, is granted to ch0.
REQ-035 Round robin: NUM_CH=4, all in_valid high, every beat with last=1, out_ready=1 -> out_ch sequence 0,1,2,3,0; data matches each source.
REQ-036 Packet lock: ch1 sends 3 beats (last on beat 3) while ch0 and ch3 are valid -> out_ch=1 for three consecutive beats, then ch3 is granted (ptr=2).
REQ-037 Backpressure: out_ready low for 4 cycles with out_valid high -> out_data stable, in_ready all 0; on release, no beat is lost or duplicated.
REQ-038 Fixed mode: ARB_MODE=0, ch1 and ch3 valid continuously with single-beat packets -> ch1 always granted and ch3 starves.
REQ-039 Idle gap: no valids, out_ready=1 -> out_valid falls one cycle after the last beat is accepted; in_ready all 0.
